div_tick_counter: RTL and testbench
===================================

// Module: div_tick_counter
// PURPOSE
//  Downstream consumer of the clock divider outputs (clk/2, clk/3 levels), sampled as data in the source clk domain.
//  Each rising edge of the sampled divided signal becomes a one-cycle tick strobe.
//  Ticks are counted against a programmable terminal, giving a periodic wrap strobe for slow-rate logic.
//  The input period is measured in clk cycles, so bring-up and verification can confirm the divide ratio.
// PARAMETERS
//  CNT_W  8  width of tick counter and terminal
//  PER_W  8  width of period measurement counter/result
// PORTS
//  clk           in   1      source clock, same clock that drives the divider
//  rst           in   1      asynchronous reset, active-high
//  div_in        in   1      divided-clock level (e.g. out2 or out3), sampled on posedge clk
//  enable        in   1      1 = tick counting allowed; 0 = counter frozen
//  clear         in   1      synchronous clear of counter and period logic
//  terminal      in   CNT_W  count value at which the counter wraps to 0
//  tick          out  1      one-cycle strobe per div_in rising edge
//  wrap          out  1      one-cycle strobe when count wraps
//  count         out  CNT_W  current tick count
//  period        out  PER_W  clk cycles between the last two div_in rising edges
//  period_valid  out  1      period holds a real measurement
//  period_sat    out  1      last measured period saturated at 2^PER_W-1
// BEHAVIOUR
//  Reset (async, rst=1): all flops 0; outputs tick=wrap=0, count=0, period=0, period_valid=0, period_sat=0, state=IDLE.
//  Edge detect:
//  - s1<=div_in, s2<=s1; rise = s1 & ~s2; tick<=rise.
//  - If div_in is sampled 0 at edge n-1 and 1 at edge n, tick is high only in the cycle after edge n+1.
//  FSM (state register, 2 bits):
//  - IDLE: enable=1 -> ARM.
//  - ARM: waits for the first rise, so counting aligns to a full input period. On rise: count stays 0, -> RUN.
//  - RUN: on each rise, count<=count+1. If count==terminal on that rise: count<=0 and wrap<=1, in the same cycle as tick.
//  - RUN or ARM with enable=0 -> IDLE; count holds its value.
//  - terminal=0: every rise in RUN wraps; wrap has the same timing as tick.
//  - terminal changed mid-run: takes effect at the next compare. If count>terminal, count increments to 2^CNT_W-1, then rolls to 0 without wrap.
//  clear=1:
//  - count<=0; per_cnt<=0; period_valid<=0; period_sat<=0; period holds its value.
//  - State -> ARM if enable=1, else IDLE.
//  - Overrides a simultaneous rise: no count, no wrap. tick still fires.
//  Period:
//  - per_cnt increments every clk and saturates at 2^PER_W-1.
//  - On rise: period<=per_cnt+1 (saturating); per_cnt<=0.
//  - period_valid<=1 from the second rise after reset/clear onward.
//  - period_sat<=1 if the captured value is 2^PER_W-1, cleared by the next non-saturated capture.
//  - Expected: clk/2 -> period=2, clk/3 -> period=3.
//  Reset mid-operation: asynchronous return to reset values. The first tick after release needs a fresh 0->1 of div_in as seen by s1/s2.
//  Latency: div_in edge to tick/wrap/count update = 2 clk.
// TESTING
//  1. div_in=clk/2 toggle, enable=1, terminal=3.
//     -> tick every 2 cycles; count 0,1,2,3,0.
//     -> wrap with every 4th tick after ARM; period=2; period_valid after the 2nd tick.
//  2. div_in=clk/3 pulse, terminal=0.
//     -> wrap coincident with every tick in RUN; period=3; count stays 0.
//  3. enable dropped at count=2 for 10 cycles, then raised.
//     -> count holds 2; first rise after re-enable only re-arms (ARM); the following rise gives count=3.
//  4. clear asserted in the same cycle as rise at count==terminal.
//     -> tick=1, wrap=0, count=0, period_valid=0.
//  5. div_in held low for 300 cycles, PER_W=8, then two rises.
//     -> period=255, period_sat=1; next clk/2 period -> period=2, period_sat=0.
//  6. rst pulsed mid-RUN with div_in high.
//     -> all outputs 0 immediately; no tick until div_in goes low, then high again.

Source files
------------

// File: rtl/div_tick_counter.sv
// Counts rising edges of a divided-clock level sampled in the source clock domain,
// with programmable wrap strobe and input-period measurement.
module div_tick_counter #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned PER_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_in,
  input  logic             enable,
  input  logic             clear,
  input  logic [CNT_W-1:0] terminal,
  output logic             tick,
  output logic             wrap,
  output logic [CNT_W-1:0] count,
  output logic [PER_W-1:0] period,
  output logic             period_valid,
  output logic             period_sat
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic [PER_W-1:0] PER_MAX = '1;

  state_t           state;
  state_t           state_nxt;
  logic             s1;
  logic             s2;
  logic             v1;
  logic             v2;
  logic             rise;
  logic             cnt_step;
  logic             cnt_wrap;
  logic             first_seen;
  logic [PER_W-1:0] per_cnt;
  logic [PER_W-1:0] per_inc;

  // v1/v2 mark s1/s2 as holding real samples, so a level that is already high
  // at reset release is not mistaken for a fresh 0->1 transition.
  assign rise = s1 & ~s2 & v2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      s1 <= div_in;
      s2 <= s1;
      v1 <= 1'b1;
      v2 <= v1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = enable ? ARM : IDLE;
    end else begin
      case (state)
        IDLE:    if (enable) state_nxt = ARM;
        ARM: begin
          if (!enable)  state_nxt = IDLE;
          else if (rise) state_nxt = RUN;
        end
        RUN:     if (!enable) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_step = 1'b0;
    cnt_wrap = 1'b0;
    if (!clear && enable && (state == RUN) && rise) begin
      if (count == terminal) cnt_wrap = 1'b1;
      else                   cnt_step = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick  <= 1'b0;
      wrap  <= 1'b0;
      count <= '0;
    end else begin
      tick <= rise;
      wrap <= cnt_wrap;
      if (clear || cnt_wrap) count <= '0;
      else if (cnt_step)     count <= count + 1'b1;
    end
  end

  assign per_inc = (per_cnt == PER_MAX) ? PER_MAX : per_cnt + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_cnt      <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      period_sat   <= 1'b0;
      first_seen   <= 1'b0;
    end else if (clear) begin
      per_cnt      <= '0;
      period_valid <= 1'b0;
      period_sat   <= 1'b0;
      first_seen   <= 1'b0;
    end else if (rise) begin
      per_cnt    <= '0;
      period     <= per_inc;
      period_sat <= (per_inc == PER_MAX);
      first_seen <= 1'b1;
      if (first_seen) period_valid <= 1'b1;
    end else begin
      per_cnt <= per_inc;
    end
  end

endmodule

// File: tb/tb_div_tick_counter.sv
// Directed vector bench for div_tick_counter: table of per-cycle stimulus and
// hand-computed outputs, plus reset and saturation sequences.
module tb_div_tick_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       div_in;
  logic       enable;
  logic       clear;
  logic [7:0] terminal;
  logic       tick;
  logic       wrap;
  logic [7:0] count;
  logic [7:0] period;
  logic       period_valid;
  logic       period_sat;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       d;
    logic       en;
    logic       clr;
    logic [7:0] term;
    logic       t;
    logic       w;
    logic [7:0] c;
    logic [7:0] p;
    logic       pv;
    logic       ps;
  } vec_t;

  vec_t vecs[$];

  div_tick_counter #(.CNT_W(8), .PER_W(8)) dut (
    .clk(clk), .rst(rst), .div_in(div_in), .enable(enable), .clear(clear),
    .terminal(terminal), .tick(tick), .wrap(wrap), .count(count),
    .period(period), .period_valid(period_valid), .period_sat(period_sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic d, input logic en, input logic clr, input logic [7:0] term,
                     input logic t, input logic w, input logic [7:0] c, input logic [7:0] p,
                     input logic pv, input logic ps);
    vec_t v;
    v.d = d; v.en = en; v.clr = clr; v.term = term;
    v.t = t; v.w = w; v.c = c; v.p = p; v.pv = pv; v.ps = ps;
    vecs.push_back(v);
  endtask

  task automatic step(input logic d);
    div_in = d;
    @(posedge clk);
    #1;
    @(negedge clk);
  endtask

  initial begin
    //   d en clr term | t w c p pv ps
    // clk/2, terminal 3
    add(0,1,0,3, 0,0,0,0,0,0);
    add(1,1,0,3, 0,0,0,0,0,0);
    add(0,1,0,3, 1,0,0,3,0,0);
    add(1,1,0,3, 0,0,0,3,0,0);
    add(0,1,0,3, 1,0,1,2,1,0);
    add(1,1,0,3, 0,0,1,2,1,0);
    add(0,1,0,3, 1,0,2,2,1,0);
    add(1,1,0,3, 0,0,2,2,1,0);
    add(0,1,0,3, 1,0,3,2,1,0);
    add(1,1,0,3, 0,0,3,2,1,0);
    add(0,1,0,3, 1,1,0,2,1,0);
    add(1,1,0,3, 0,0,0,2,1,0);
    add(0,1,0,3, 1,0,1,2,1,0);
    add(1,1,0,3, 0,0,1,2,1,0);
    add(0,1,0,3, 1,0,2,2,1,0);
    add(1,1,0,3, 0,0,2,2,1,0);
    add(0,1,0,3, 1,0,3,2,1,0);
    add(1,1,0,3, 0,0,3,2,1,0);
    // clear coincident with the wrapping rise
    add(0,1,1,3, 1,0,0,2,0,0);
    add(1,1,0,3, 0,0,0,2,0,0);
    add(0,1,0,3, 1,0,0,2,0,0);
    add(1,1,0,3, 0,0,0,2,0,0);
    add(0,1,0,3, 1,0,1,2,1,0);
    add(1,1,0,3, 0,0,1,2,1,0);
    add(0,1,0,3, 1,0,2,2,1,0);
    // enable low for 10 cycles at count 2
    add(1,0,0,3, 0,0,2,2,1,0);
    add(0,0,0,3, 1,0,2,2,1,0);
    add(1,0,0,3, 0,0,2,2,1,0);
    add(0,0,0,3, 1,0,2,2,1,0);
    add(1,0,0,3, 0,0,2,2,1,0);
    add(0,0,0,3, 1,0,2,2,1,0);
    add(1,0,0,3, 0,0,2,2,1,0);
    add(0,0,0,3, 1,0,2,2,1,0);
    add(1,0,0,3, 0,0,2,2,1,0);
    add(0,0,0,3, 1,0,2,2,1,0);
    add(1,1,0,3, 0,0,2,2,1,0);
    add(0,1,0,3, 1,0,2,2,1,0);
    add(1,1,0,3, 0,0,2,2,1,0);
    add(0,1,0,3, 1,0,3,2,1,0);
    add(1,1,0,3, 0,0,3,2,1,0);
    add(0,1,0,3, 1,1,0,2,1,0);
    // clk/3, terminal 0
    add(1,1,0,0, 0,0,0,2,1,0);
    add(0,1,0,0, 1,1,0,2,1,0);
    add(0,1,0,0, 0,0,0,2,1,0);
    add(1,1,0,0, 0,0,0,2,1,0);
    add(0,1,0,0, 1,1,0,3,1,0);
    add(0,1,0,0, 0,0,0,3,1,0);
    add(1,1,0,0, 0,0,0,3,1,0);
    add(0,1,0,0, 1,1,0,3,1,0);
    add(0,1,0,0, 0,0,0,3,1,0);
    add(1,1,0,0, 0,0,0,3,1,0);
    add(0,1,0,0, 1,1,0,3,1,0);

    rst = 1'b1; div_in = 1'b0; enable = 1'b0; clear = 1'b0; terminal = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tick",  tick, 0);
    chk("rst_wrap",  wrap, 0);
    chk("rst_count", count, 0);
    chk("rst_period", period, 0);
    chk("rst_pvalid", period_valid, 0);
    chk("rst_psat",  period_sat, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int unsigned i = 0; i < vecs.size(); i++) begin
      div_in = vecs[i].d; enable = vecs[i].en; clear = vecs[i].clr; terminal = vecs[i].term;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_tick", i),   tick,         vecs[i].t);
      chk($sformatf("v%0d_wrap", i),   wrap,         vecs[i].w);
      chk($sformatf("v%0d_count", i),  count,        vecs[i].c);
      chk($sformatf("v%0d_period", i), period,       vecs[i].p);
      chk($sformatf("v%0d_pvalid", i), period_valid, vecs[i].pv);
      chk($sformatf("v%0d_psat", i),   period_sat,   vecs[i].ps);
      @(negedge clk);
    end
    clear = 1'b0; enable = 1'b1;

    // async reset mid-RUN with div_in high and a rise pending
    terminal = 8'd5;
    step(1);
    step(0);
    chk("pre_rst_count", count, 1);
    step(1);
    rst = 1'b1;
    #1;
    chk("arst_tick", tick, 0);
    chk("arst_count", count, 0);
    chk("arst_period", period, 0);
    chk("arst_pvalid", period_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step(1);
      chk($sformatf("post_rst_hi%0d_tick", k), tick, 0);
    end
    step(0);
    chk("post_rst_lo_tick", tick, 0);
    step(1);
    chk("post_rst_rise_tick0", tick, 0);
    step(1);
    chk("post_rst_rise_tick1", tick, 1);
    chk("post_rst_rise_count", count, 0);

    // long low interval saturates the period measurement
    for (int k = 0; k < 300; k++) step(0);
    step(1);
    step(0);
    chk("sat_tick", tick, 1);
    chk("sat_period", period, 255);
    chk("sat_flag", period_sat, 1);
    chk("sat_pvalid", period_valid, 1);
    chk("sat_count", count, 1);
    step(1);
    step(0);
    chk("unsat_period", period, 2);
    chk("unsat_flag", period_sat, 0);
    chk("unsat_count", count, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
